dram_responder: RTL and testbench

- Synthesizable single-clock responder for the 144-bit DRAM user command interface. It acts as a stand-in DRAM controller so the async DRAM bridge can be exercised on-chip and in simulation without the real memory controller.
- Accepts 2-beat write and read bursts into a local block-RAM store. Returns read bursts after a fixed, programmable latency.
- Drives ready and enforces 2-cycle command spacing.

---
 rtl/dram_if_pkg.sv | 16 +
 rtl/dram_responder_if.sv | 25 ++
 rtl/dram_responder_ram.sv | 35 +++
 rtl/dram_responder.sv | 184 ++++++++++++++++++
 tb/tb_dram_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dram_if_pkg.sv
// Shared constants and FSM state type for the 144-bit DRAM user command interface.
package dram_if_pkg;

  localparam int DRAM_DATA_W    = 144;
  localparam int DRAM_BE_W      = 18;
  localparam int DRAM_ADDR_W    = 32;
  localparam int DRAM_BURST_LEN = 2;
  localparam int DRAM_LANE_W    = DRAM_DATA_W / DRAM_BE_W;

  typedef enum logic [1:0] {
    IDLE,
    CMD2,
    REFRESH
  } state_e;

endpackage

// File: rtl/dram_responder_if.sv
// DRAM user command/data bus: master is the bridge side, slave is the responder.
interface dram_responder_if;
  import dram_if_pkg::*;

  logic [DRAM_ADDR_W-1:0] cmd_address;
  logic                   cmd_rnw;
  logic                   cmd_en;
  logic [DRAM_DATA_W-1:0] wr_data;
  logic [DRAM_BE_W-1:0]   wr_be;
  logic [DRAM_DATA_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   ready;
  logic                   protocol_err;

  modport master (
    output cmd_address, cmd_rnw, cmd_en, wr_data, wr_be,
    input  rd_data, rd_valid, ready, protocol_err
  );

  modport slave (
    input  cmd_address, cmd_rnw, cmd_en, wr_data, wr_be,
    output rd_data, rd_valid, ready, protocol_err
  );

endinterface

// File: rtl/dram_responder_ram.sv
// Simple dual-port line store: byte-lane write enables, one-cycle registered read.
module dram_responder_ram
  import dram_if_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_wrEn,
  input  logic [ADDR_W-1:0]      i_wrAddr,
  input  logic [DRAM_DATA_W-1:0] i_wrData,
  input  logic [DRAM_BE_W-1:0]   i_wrBe,
  input  logic                   i_rdEn,
  input  logic [ADDR_W-1:0]      i_rdAddr,
  output logic [DRAM_DATA_W-1:0] o_rdData
);

  logic [DRAM_DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DRAM_DATA_W-1:0] r_rdData;

  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      for (int i = 0; i < DRAM_BE_W; i++) begin
        if (i_wrBe[i]) begin
          r_mem[i_wrAddr][DRAM_LANE_W*i +: DRAM_LANE_W] <= i_wrData[DRAM_LANE_W*i +: DRAM_LANE_W];
        end
      end
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/dram_responder.sv
// Stand-in DRAM controller: 2-beat bursts into local RAM, reads returned after RD_LATENCY cycles.
// Optional periodic refresh stalls are enabled by defining DRAM_RESPONDER_REFRESH_STALL_EN.
module dram_responder
  import dram_if_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int REFRESH_PERIOD = 1024,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic            dram_clk,
  input  logic            dram_rst_n,
  dram_responder_if.slave bus
);

  localparam int LINE_LSB = $clog2(DRAM_BURST_LEN);
  localparam int BASE_W   = ADDR_W - LINE_LSB;

  state_e                 r_state;
  state_e                 w_nextState;
  logic                   r_live;
  logic                   w_ready;
  logic                   w_accept;
  logic                   r_err;
  logic [BASE_W-1:0]      w_cmdBase;
  logic                   r_wrBeat1;
  logic [BASE_W-1:0]      r_wrBase;
  logic                   w_wrEn;
  logic [ADDR_W-1:0]      w_wrAddr;
  logic [RD_LATENCY-1:0]  r_pipeV;
  logic [BASE_W-1:0]      r_pipeBase [RD_LATENCY];
  logic                   w_rdBeat0;
  logic                   w_rdBeat1;
  logic                   w_rdEn;
  logic [ADDR_W-1:0]      w_rdAddr;
  logic                   r_rdValid;
  logic [DRAM_DATA_W-1:0] w_ramQ;
  logic                   w_refReq;
  logic                   w_refPend;
  logic                   w_refDone;
  logic                   w_unusedAddr;

  assign w_cmdBase    = bus.cmd_address[ADDR_W-1:LINE_LSB];
  assign w_accept     = bus.cmd_en && w_ready;
  assign w_unusedAddr = ^{bus.cmd_address[DRAM_ADDR_W-1:ADDR_W], bus.cmd_address[LINE_LSB-1:0]};

`ifdef DRAM_RESPONDER_REFRESH_STALL_EN
  localparam int RC_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RL_W = $clog2(REFRESH_CYCLES + 1);

  logic [RC_W-1:0] r_refCnt;
  logic [RL_W-1:0] r_refLeft;
  logic            r_refPending;
  logic            w_wrap;

  assign w_wrap    = (r_refCnt == RC_W'(REFRESH_PERIOD - 1));
  assign w_refReq  = r_refPending || w_wrap;
  assign w_refPend = r_refPending;
  assign w_refDone = (r_refLeft == RL_W'(1));

  // A wrap seen while already refreshing is folded into the current refresh.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_refCnt     <= '0;
      r_refLeft    <= '0;
      r_refPending <= 1'b0;
    end else begin
      r_refCnt <= w_wrap ? '0 : r_refCnt + 1'b1;
      if ((w_nextState == REFRESH) && (r_state != REFRESH)) begin
        r_refPending <= 1'b0;
        r_refLeft    <= RL_W'(REFRESH_CYCLES);
      end else begin
        if (r_state == REFRESH) begin
          r_refLeft <= r_refLeft - 1'b1;
        end
        if (w_wrap && (r_state != REFRESH)) begin
          r_refPending <= 1'b1;
        end
      end
    end
  end
`else
  logic w_unusedRefCfg;

  assign w_refReq       = 1'b0;
  assign w_refPend      = 1'b0;
  assign w_refDone      = 1'b1;
  assign w_unusedRefCfg = (REFRESH_PERIOD == REFRESH_CYCLES);
`endif

  // r_live holds ready low until the first edge after reset release.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = CMD2;
        end else if (w_refReq) begin
          w_nextState = REFRESH;
        end
      end
      CMD2:    w_nextState = w_refReq ? REFRESH : IDLE;
      REFRESH: w_nextState = w_refDone ? IDLE : REFRESH;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_ready = r_live && (r_state == IDLE) && !w_refPend;
  end

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_err     <= 1'b0;
      r_wrBeat1 <= 1'b0;
      r_wrBase  <= '0;
    end else begin
      if (bus.cmd_en && !w_ready) begin
        r_err <= 1'b1;
      end
      r_wrBeat1 <= w_accept && !bus.cmd_rnw;
      if (w_accept) begin
        r_wrBase <= w_cmdBase;
      end
    end
  end

  // Both write beats come straight off the bus: beat0 in the command cycle, beat1 in CMD2.
  assign w_wrEn   = (w_accept && !bus.cmd_rnw) || r_wrBeat1;
  assign w_wrAddr = r_wrBeat1 ? {r_wrBase, 1'b1} : {w_cmdBase, 1'b0};

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_pipeV   <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_pipeV   <= {r_pipeV[RD_LATENCY-2:0], w_accept && bus.cmd_rnw};
      r_rdValid <= w_rdEn;
    end
  end

  always_ff @(posedge dram_clk) begin
    r_pipeBase[0] <= w_cmdBase;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_pipeBase[i] <= r_pipeBase[i-1];
    end
  end

  // RAM is read one cycle ahead of each beat; 2-cycle spacing keeps the two taps exclusive.
  assign w_rdBeat0 = r_pipeV[RD_LATENCY-2];
  assign w_rdBeat1 = r_pipeV[RD_LATENCY-1];
  assign w_rdEn    = w_rdBeat0 || w_rdBeat1;
  assign w_rdAddr  = w_rdBeat0 ? {r_pipeBase[RD_LATENCY-2], 1'b0}
                               : {r_pipeBase[RD_LATENCY-1], 1'b1};

  dram_responder_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk    (dram_clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_wrAddr),
    .i_wrData (bus.wr_data),
    .i_wrBe   (bus.wr_be),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_ramQ)
  );

  assign bus.rd_data      = r_rdValid ? w_ramQ : '0;
  assign bus.rd_valid     = r_rdValid;
  assign bus.ready        = w_ready;
  assign bus.protocol_err = r_err;

endmodule

// File: tb/tb_dram_responder.sv
// Randomized scoreboard bench for dram_responder: expected read beats (cycle and data) are
// queued at command issue from a byte-array memory model and popped by an independent monitor.
module tb_dram_responder;

  localparam int LAT    = 4;
  localparam int NBASE  = 32;
  localparam int NRAND  = 200;

  typedef struct {
    int           cyc;
    logic [143:0] data;
  } exp_t;

  logic dramClk;
  logic dramRstN;
  int   cycleCnt;
  int   total;
  int   bad;
  logic expErr;

  logic [143:0] modelMem [2*NBASE];
  int           lastRead [NBASE];
  exp_t         expQ [$];

  dram_responder_if bus ();

  dram_responder #(
    .RD_LATENCY (LAT)
  ) dut (
    .dram_clk   (dramClk),
    .dram_rst_n (dramRstN),
    .bus        (bus)
  );

  initial dramClk = 1'b0;
  always #5 dramClk = ~dramClk;

  initial cycleCnt = 0;
  always @(posedge dramClk) cycleCnt <= cycleCnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic stepCycle();
    @(posedge dramClk);
    #1;
  endtask

  function automatic logic [143:0] rand144();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[143:0];
  endfunction

  function automatic logic [31:0] mkAddr(input int base);
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_FC00) | (32'(base) << 1) | ($urandom() & 32'h1);
    return a;
  endfunction

  function automatic logic [143:0] mergeBytes(input logic [143:0] old, input logic [143:0] d,
                                              input logic [17:0] be);
    logic [143:0] r;
    r = old;
    for (int i = 0; i < 18; i++) begin
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // One command plus its CMD2 cycle; optionally an illegal cmd_en is driven during CMD2.
  task automatic applyStimulus(input bit rnw, input int base, input logic [143:0] d0,
                               input logic [143:0] d1, input logic [17:0] b0, input logic [17:0] b1,
                               input bit injectBad, input bit badRnw, input int badBase);
    checkOutput("ready_idle", 144'(bus.ready), 144'(1));
    bus.cmd_en      = 1'b1;
    bus.cmd_rnw     = rnw;
    bus.cmd_address = mkAddr(base);
    bus.wr_data     = d0;
    bus.wr_be       = b0;
    if (rnw) begin
      expQ.push_back('{cycleCnt + LAT,     modelMem[2*base]});
      expQ.push_back('{cycleCnt + LAT + 1, modelMem[2*base+1]});
      lastRead[base] = cycleCnt;
    end else begin
      modelMem[2*base] = mergeBytes(modelMem[2*base], d0, b0);
    end
    stepCycle();
    checkOutput("ready_cmd2", 144'(bus.ready), 144'(0));
    bus.cmd_en      = injectBad;
    bus.cmd_rnw     = injectBad ? badRnw : 1'($urandom());
    bus.cmd_address = injectBad ? mkAddr(badBase) : $urandom();
    bus.wr_data     = d1;
    bus.wr_be       = b1;
    if (!rnw) modelMem[2*base+1] = mergeBytes(modelMem[2*base+1], d1, b1);
    if (injectBad) expErr = 1'b1;
    stepCycle();
    bus.cmd_en      = 1'b0;
    bus.cmd_rnw     = 1'($urandom());
    bus.cmd_address = $urandom();
    bus.wr_data     = rand144();
    bus.wr_be       = 18'($urandom());
    checkOutput("protocol_err", 144'(bus.protocol_err), 144'(expErr));
  endtask

  // Monitor: every cycle either the head beat is due or rd_valid must be low.
  always @(negedge dramClk) begin
    exp_t e;
    if (expQ.size() > 0 && expQ[0].cyc == cycleCnt) begin
      e = expQ.pop_front();
      checkOutput("rd_valid_beat", 144'(bus.rd_valid), 144'(1));
      if (bus.rd_valid === 1'b1) checkOutput("rd_data_beat", bus.rd_data, e.data);
    end else if (bus.rd_valid !== 1'b0) begin
      checkOutput("rd_valid_idle", 144'(bus.rd_valid), 144'(0));
    end
  end

  initial begin
    bit   rnw;
    int   base;
    total = 0;
    bad = 0;
    expErr = 1'b0;
    for (int i = 0; i < NBASE; i++) lastRead[i] = -100;
    dramRstN        = 1'b0;
    bus.cmd_en      = 1'b0;
    bus.cmd_rnw     = 1'b0;
    bus.cmd_address = '0;
    bus.wr_data     = '0;
    bus.wr_be       = '0;

    repeat (3) stepCycle();
    checkOutput("reset_ready", 144'(bus.ready), 144'(0));
    checkOutput("reset_rd_valid", 144'(bus.rd_valid), 144'(0));
    checkOutput("reset_rd_data", bus.rd_data, 144'(0));
    checkOutput("reset_protocol_err", 144'(bus.protocol_err), 144'(0));
    dramRstN = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 144'(bus.ready), 144'(0));
    stepCycle();
    checkOutput("ready_first_edge", 144'(bus.ready), 144'(1));

    $display("[TB] filling %0d lines", 2*NBASE);
    for (int b = 0; b < NBASE; b++) applyStimulus(1'b0, b, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);

    $display("[TB] directed bursts");
    applyStimulus(1'b0, 8, {18{8'hA5}}, {18{8'h5A}}, '1, '1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    repeat (LAT) stepCycle();
    applyStimulus(1'b0, 8, {18{8'hFF}}, rand144(), 18'h00001, 18'h00000, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    for (int b = 0; b < 3; b++) applyStimulus(1'b1, b, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    repeat (LAT + 2) stepCycle();

    $display("[TB] illegal commands during CMD2");
    applyStimulus(1'b0, 3, rand144(), rand144(), '1, '1, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 5, rand144(), rand144(), '1, '1, 1'b1, 1'b1, 6);
    applyStimulus(1'b1, 3, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 4, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    repeat (LAT + 2) stepCycle();
    checkOutput("protocol_err_sticky", 144'(bus.protocol_err), 144'(1));

    $display("[TB] reset with a read in flight");
    applyStimulus(1'b1, 7, rand144(), rand144(), '1, '1, 1'b0, 1'b0, 0);
    dramRstN = 1'b0;
    expQ.delete();
    expErr = 1'b0;
    #1;
    checkOutput("midreset_ready", 144'(bus.ready), 144'(0));
    checkOutput("midreset_rd_valid", 144'(bus.rd_valid), 144'(0));
    checkOutput("midreset_protocol_err", 144'(bus.protocol_err), 144'(0));
    repeat (LAT + 2) stepCycle();
    dramRstN = 1'b1;
    #1;
    checkOutput("release_ready_low", 144'(bus.ready), 144'(0));
    stepCycle();
    checkOutput("release_ready_high", 144'(bus.ready), 144'(1));
    repeat (LAT) stepCycle();

    $display("[TB] random traffic: %0d commands", NRAND);
    for (int n = 0; n < NRAND; n++) begin
      rnw  = 1'($urandom());
      base = int'($urandom_range(0, NBASE - 1));
      if (!rnw && (cycleCnt - lastRead[base] <= LAT + 2)) rnw = 1'b1;
      applyStimulus(rnw, base, rand144(), rand144(), 18'($urandom()), 18'($urandom()), 1'b0, 1'b0, 0);
      repeat ($urandom_range(0, 2)) begin
        stepCycle();
        checkOutput("ready_gap", 144'(bus.ready), 144'(1));
      end
    end

    for (int w = 0; w < 40 && expQ.size() > 0; w++) stepCycle();
    checkOutput("drain_queue_empty", 144'(expQ.size()), 144'(0));
    repeat (5) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
